// File: rtl/dut_model_pkg.sv
// dut_model_pkg: shared constants for the dut_model responder and its
// fault injector (operation encoding, pipeline limits, fault period width).
package dut_model_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int LATENCY_MAX    = 8;
  localparam int FAULT_PERIOD_W = 16;

endpackage

// File: rtl/dut_model_fault.sv
// dut_fault_injector: sits on the final pipeline stage of dut_model.
// Counts valid results, corrupts one bit of every Nth result and keeps a
// saturating tally of the faults that were actually presented on the output.
// Instantiated only when DUT_MODEL_FAULT_EN is defined.
module dut_fault_injector
  import dut_model_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_vld,
  input  logic [WIDTH-1:0]          i_result,
  input  logic                      i_inject,
  input  logic [FAULT_PERIOD_W-1:0] i_fault_period,
  input  logic [$clog2(WIDTH)-1:0]  i_fault_bit,
  input  logic                      i_fault_q,
  output logic [WIDTH-1:0]          o_result,
  output logic                      o_fault,
  output logic [WIDTH-1:0]          o_fault_ctr
);

  logic [FAULT_PERIOD_W-1:0] r_pcnt;
  logic [WIDTH-1:0]          r_fault_ctr;
  logic                      w_armed;
  logic                      w_hit;
  logic [WIDTH-1:0]          w_mask;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    sat_inc = (v == '1) ? v : v + 1'b1;
  endfunction

  // ">=" rather than "==" so a period lowered below the current count
  // still fires on the very next valid result.
  assign w_armed = i_inject && (i_fault_period != '0);
  assign w_hit   = w_armed && i_vld && (r_pcnt >= (i_fault_period - 1'b1));

  // A bit index past the top of the word shifts the one out, so nothing is
  // inverted while the fault is still flagged and counted.
  assign w_mask   = {{(WIDTH-1){1'b0}}, 1'b1} << i_fault_bit;
  assign o_result = w_hit ? (i_result ^ w_mask) : i_result;
  assign o_fault  = w_hit;

  // Period counter: held at zero while disarmed, restarts after each fault.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pcnt <= '0;
    end else if (!w_armed) begin
      r_pcnt <= '0;
    end else if (i_vld) begin
      r_pcnt <= w_hit ? '0 : r_pcnt + 1'b1;
    end
  end

  // Fault tally follows the registered o_fault, so it lags it by one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fault_ctr <= '0;
    end else if (i_fault_q) begin
      r_fault_ctr <= sat_inc(r_fault_ctr);
    end
  end

  assign o_fault_ctr = r_fault_ctr;

endmodule

// File: rtl/dut_model.sv
// dut_model: responder end of the drive/result conduit. Adds or subtracts
// two operands through a fixed LATENCY-cycle pipeline. Define
// DUT_MODEL_FAULT_EN to include the deliberate single-bit fault injector;
// without it results are exact and the fault outputs are tied to zero.
module dut_model
  import dut_model_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic                      clk_dut,
  input  logic                      reset,
  input  logic                      i_enable,
  input  logic                      i_op,
  input  logic [WIDTH-1:0]          i_drive_a,
  input  logic [WIDTH-1:0]          i_drive_b,
  input  logic                      i_inject,
  input  logic [FAULT_PERIOD_W-1:0] i_fault_period,
  input  logic [$clog2(WIDTH)-1:0]  i_fault_bit,
  output logic [WIDTH-1:0]          o_dut_out,
  output logic                      o_valid,
  output logic                      o_fault,
  output logic [WIDTH-1:0]          o_fault_ctr
);

  // Operand stages ahead of the output register; the output register is
  // the last of the LATENCY stages.
  localparam int STG = (LATENCY > 1) ? LATENCY - 1 : 1;

  if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dut_model: LATENCY must be within 1..LATENCY_MAX");
  end

  logic signed [WIDTH-1:0] w_a_fin;
  logic signed [WIDTH-1:0] w_b_fin;
  logic                    w_op_fin;
  logic                    w_vld_fin;
  logic signed [WIDTH-1:0] w_res_fin;
  logic [WIDTH-1:0]        w_res_out;
  logic                    w_fault_fin;
  logic [WIDTH-1:0]        w_fault_ctr;

  logic [WIDTH-1:0]        r_dut_out;
  logic                    r_valid;
  logic                    r_fault;

  // Two's complement wrap: carry and borrow fall off the top.
  function automatic logic signed [WIDTH-1:0] addsub(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic                    op
  );
    addsub = (op == OP_SUB) ? (a - b) : (a + b);
  endfunction

  if (LATENCY > 1) begin : g_pipe
    logic signed [WIDTH-1:0] r_a_p   [STG];
    logic signed [WIDTH-1:0] r_b_p   [STG];
    logic                    r_op_p  [STG];
    logic                    r_vld_p [STG];

    // Stage 0 onward: free-running shift; a bubble is just a zero tag.
    always_ff @(posedge clk_dut or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < STG; s++) begin
          r_a_p[s]   <= '0;
          r_b_p[s]   <= '0;
          r_op_p[s]  <= 1'b0;
          r_vld_p[s] <= 1'b0;
        end
      end else begin
        r_a_p[0]   <= i_drive_a;
        r_b_p[0]   <= i_drive_b;
        r_op_p[0]  <= i_op;
        r_vld_p[0] <= i_enable;
        for (int s = 1; s < STG; s++) begin
          r_a_p[s]   <= r_a_p[s-1];
          r_b_p[s]   <= r_b_p[s-1];
          r_op_p[s]  <= r_op_p[s-1];
          r_vld_p[s] <= r_vld_p[s-1];
        end
      end
    end

    assign w_a_fin   = r_a_p[STG-1];
    assign w_b_fin   = r_b_p[STG-1];
    assign w_op_fin  = r_op_p[STG-1];
    assign w_vld_fin = r_vld_p[STG-1];
  end else begin : g_nopipe
    assign w_a_fin   = i_drive_a;
    assign w_b_fin   = i_drive_b;
    assign w_op_fin  = i_op;
    assign w_vld_fin = i_enable;
  end

  assign w_res_fin = addsub(w_a_fin, w_b_fin, w_op_fin);

`ifdef DUT_MODEL_FAULT_EN
  dut_fault_injector #(
    .WIDTH (WIDTH)
  ) u_fault_injector (
    .i_clk          (clk_dut),
    .i_rst          (reset),
    .i_vld          (w_vld_fin),
    .i_result       (w_res_fin),
    .i_inject       (i_inject),
    .i_fault_period (i_fault_period),
    .i_fault_bit    (i_fault_bit),
    .i_fault_q      (r_fault),
    .o_result       (w_res_out),
    .o_fault        (w_fault_fin),
    .o_fault_ctr    (w_fault_ctr)
  );
`else
  logic w_unused_fault_cfg;
  assign w_unused_fault_cfg = ^{i_inject, i_fault_period, i_fault_bit};
  assign w_res_out   = w_res_fin;
  assign w_fault_fin = 1'b0;
  assign w_fault_ctr = '0;
`endif

  // Final stage: result held across bubbles, valid/fault pulse per result.
  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      r_dut_out <= '0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_valid <= w_vld_fin;
      r_fault <= w_vld_fin && w_fault_fin;
      if (w_vld_fin) begin
        r_dut_out <= w_res_out;
      end
    end
  end

  assign o_dut_out   = r_dut_out;
  assign o_valid     = r_valid;
  assign o_fault     = r_fault;
  assign o_fault_ctr = w_fault_ctr;

endmodule

// File: tb/tb_dut_model.sv
// tb_dut_model: table-driven vectors plus hand-written sequences, checked
// cycle by cycle against a scoreboard queue of expected results.
module tb_dut_model;
  import dut_model_pkg::*;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 2;

  logic                      clk_dut = 1'b0;
  logic                      reset;
  logic                      i_enable;
  logic                      i_op;
  logic [WIDTH-1:0]          i_drive_a;
  logic [WIDTH-1:0]          i_drive_b;
  logic                      i_inject;
  logic [FAULT_PERIOD_W-1:0] i_fault_period;
  logic [$clog2(WIDTH)-1:0]  i_fault_bit;
  logic [WIDTH-1:0]          o_dut_out;
  logic                      o_valid;
  logic                      o_fault;
  logic [WIDTH-1:0]          o_fault_ctr;

  always #5 clk_dut = ~clk_dut;

  dut_model #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk_dut        (clk_dut),
    .reset          (reset),
    .i_enable       (i_enable),
    .i_op           (i_op),
    .i_drive_a      (i_drive_a),
    .i_drive_b      (i_drive_b),
    .i_inject       (i_inject),
    .i_fault_period (i_fault_period),
    .i_fault_bit    (i_fault_bit),
    .o_dut_out      (o_dut_out),
    .o_valid        (o_valid),
    .o_fault        (o_fault),
    .o_fault_ctr    (o_fault_ctr)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic [WIDTH-1:0] exp;
  } vec_t;

  typedef struct {
    int               due;
    logic [WIDTH-1:0] exp;
  } sb_t;

  sb_t              sb_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  logic [WIDTH-1:0] m_last   = '0;
  logic [WIDTH-1:0] m_ctr    = '0;
  bit               m_pend   = 1'b0;
`ifdef DUT_MODEL_FAULT_EN
  int               m_pcnt   = 0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge; enabled cycles push
  // their expected result with the cycle on which it must appear.
  task automatic drive(input logic en, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic op, input logic [WIDTH-1:0] exp);
    @(negedge clk_dut);
    i_enable  = en;
    i_drive_a = a;
    i_drive_b = b;
    i_op      = op;
    if (en) sb_q.push_back('{due: cyc + LATENCY, exp: exp});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, OP_ADD, '0);
  endtask

  // Monitor: sample just after each rising edge and compare every output.
  always @(posedge clk_dut) begin : mon
    bit               ev;
    bit               ef;
    logic [WIDTH-1:0] er;
    cyc++;
    #1;
    if (reset) begin
      sb_q.delete();
      m_last = '0;
      m_ctr  = '0;
      m_pend = 1'b0;
`ifdef DUT_MODEL_FAULT_EN
      m_pcnt = 0;
`endif
      check("rst_dut_out", o_dut_out, 0);
      check("rst_valid", o_valid, 0);
      check("rst_fault", o_fault, 0);
      check("rst_fault_ctr", o_fault_ctr, 0);
    end else begin
      if (m_pend && m_ctr != '1) m_ctr = m_ctr + 1'b1;
      m_pend = 1'b0;
      ev = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      ef = 1'b0;
      er = m_last;
`ifdef DUT_MODEL_FAULT_EN
      if (!(i_inject && i_fault_period != 0)) m_pcnt = 0;
`endif
      if (ev) begin
        er = sb_q.pop_front().exp;
`ifdef DUT_MODEL_FAULT_EN
        if (i_inject && i_fault_period != 0) begin
          if (m_pcnt >= int'(i_fault_period) - 1) begin
            ef     = 1'b1;
            m_pcnt = 0;
            er     = er ^ (32'h1 << i_fault_bit);
          end else begin
            m_pcnt++;
          end
        end
`endif
        m_last = er;
      end
      check("valid", o_valid, ev);
      check("dut_out", o_dut_out, er);
      check("fault", o_fault, ef);
      check("fault_ctr", o_fault_ctr, m_ctr);
      m_pend = ef;
    end
  end

  vec_t tbl[9];

  initial begin
    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000};
    tbl[1] = '{32'h0000_0000, 32'h0000_0001, OP_SUB, 32'hFFFF_FFFF};
    tbl[2] = '{32'h0000_000A, 32'h0000_0003, OP_SUB, 32'h0000_0007};
    tbl[3] = '{32'h0000_0005, 32'h0000_0003, OP_ADD, 32'h0000_0008};
    tbl[4] = '{32'h8000_0000, 32'h8000_0000, OP_ADD, 32'h0000_0000};
    tbl[5] = '{32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000};
    tbl[6] = '{32'h0000_04D2, 32'h0000_04D2, OP_SUB, 32'h0000_0000};
    tbl[7] = '{32'h0000_0003, 32'h0000_0005, OP_SUB, 32'hFFFF_FFFE};
    tbl[8] = '{32'hDEAD_BEEF, 32'h1111_1111, OP_ADD, 32'hEFBE_D000};

    reset          = 1'b0;
    i_enable       = 1'b0;
    i_op           = OP_ADD;
    i_drive_a      = '0;
    i_drive_b      = '0;
    i_inject       = 1'b0;
    i_fault_period = '0;
    i_fault_bit    = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk_dut);
    reset = 1'b0;
    idle(2);

    // Add wrap: a single valid pulse carrying 0.
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, OP_ADD, 32'h0);
    idle(4);

    // Subtract wrap then a plain subtract on the following cycle.
    drive(1'b1, 32'h0, 32'h1, OP_SUB, 32'hFFFF_FFFF);
    drive(1'b1, 32'd10, 32'd3, OP_SUB, 32'd7);
    idle(3);

    // Table vectors back to back.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);
    end
    idle(3);

    // Bubble: output holds 4 across the gap, then 6.
    drive(1'b1, 32'd2, 32'd2, OP_ADD, 32'd4);
    drive(1'b0, 32'd9, 32'd9, OP_ADD, 32'd0);
    drive(1'b1, 32'd3, 32'd3, OP_ADD, 32'd6);
    idle(3);

    // Fault rate: period 4 on bit 0 over 12 results.
    i_inject       = 1'b1;
    i_fault_period = 16'd4;
    i_fault_bit    = 5'd0;
    repeat (12) drive(1'b1, 32'd5, 32'd3, OP_ADD, 32'd8);
    idle(3);
`ifdef DUT_MODEL_FAULT_EN
    check("fault_ctr_after_12", o_fault_ctr, 3);
`else
    check("fault_ctr_after_12", o_fault_ctr, 0);
`endif

    // Period lowered mid-run, and a fault on the top bit.
    repeat (2) drive(1'b1, 32'd5, 32'd3, OP_ADD, 32'd8);
    i_fault_period = 16'd2;
    i_fault_bit    = 5'd31;
    repeat (5) drive(1'b1, 32'd100, 32'd1, OP_SUB, 32'd99);
    idle(3);

    // Period 1 faults every result; then injection off.
    i_fault_period = 16'd1;
    i_fault_bit    = 5'd4;
    repeat (3) drive(1'b1, 32'd1, 32'd1, OP_ADD, 32'd2);
    idle(2);
    i_inject = 1'b0;
    repeat (3) drive(1'b1, 32'd1, 32'd1, OP_ADD, 32'd2);
    idle(3);

    // Random traffic with injection running.
    i_inject       = 1'b1;
    i_fault_period = 16'd5;
    i_fault_bit    = 5'd7;
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rop;
      logic             ren;
      ra  = $urandom;
      rb  = $urandom;
      rop = 1'($urandom_range(0, 1));
      ren = ($urandom_range(0, 3) != 0);
      drive(ren, ra, rb, rop, (rop == OP_SUB) ? ra - rb : ra + rb);
    end
    idle(3);

    // Reset mid-flight: the entering transaction must never emerge and the
    // period count restarts from zero.
    i_fault_period = 16'd3;
    i_fault_bit    = 5'd2;
    idle(1);
    repeat (2) drive(1'b1, 32'd5, 32'd3, OP_ADD, 32'd8);
    drive(1'b1, 32'd40, 32'd2, OP_ADD, 32'd42);
    @(negedge clk_dut);
    i_enable = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk_dut);
    reset = 1'b0;
    idle(3);
    repeat (6) drive(1'b1, 32'd5, 32'd3, OP_ADD, 32'd8);
    idle(3);
`ifdef DUT_MODEL_FAULT_EN
    check("fault_ctr_after_reset", o_fault_ctr, 2);
`else
    check("fault_ctr_after_reset", o_fault_ctr, 0);
`endif
    i_inject = 1'b0;

    // Bounded drain of anything still expected.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk_dut);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dut_model.md
# dut_model

Synthesizable stand-in for the device under test, the responder end of the testbench drive/result conduit. It accepts the two operands from the driver and returns their sum or difference after a fixed pipeline latency. It optionally injects deliberate single-bit faults at a programmable rate so the monitor and scoreboard error paths can be exercised in hardware. It replaces the ad-hoc internal adder in the testbench top.

## Interface
- WIDTH, 32: operand and result width in bits.
- LATENCY, 2: pipeline depth in cycles. Legal range is 1..8; values outside this range are a compile-time error.

- clk_dut  in  1  sole clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- i_enable  in  1  the operands this cycle form a valid transaction.
- i_op  in  1  0 = add, 1 = subtract (a − b).
- i_drive_a  in  WIDTH  operand a, from the driver.
- i_drive_b  in  WIDTH  operand b, from the driver.
- i_inject  in  1  enables fault injection; level-sensitive.
- i_fault_period  in  16  one fault per this many valid results; 0 = never.
- i_fault_bit  in  $clog2(WIDTH)  result bit to invert when a fault is injected.
- o_dut_out  out  WIDTH  result to the monitor; reset value 0.
- o_valid  out  1  o_dut_out holds a new result this cycle; reset value 0.
- o_fault  out  1  the current result was deliberately corrupted; reset value 0.
- o_fault_ctr  out  WIDTH  total faults injected, saturating; reset value 0.

## Operation
- Every cycle, stage 0 captures i_drive_a, i_drive_b, i_op and a valid tag equal to i_enable. The pipeline always advances; a bubble is simply a tag of 0.
- Arithmetic is modulo 2^WIDTH, two's complement. Carry and borrow are discarded.
- The final stage drives the outputs:
  - On a valid tag: o_dut_out takes the result (possibly faulted), o_valid = 1, o_fault reflects injection.
  - On an invalid tag: o_dut_out holds its previous value, o_valid = 0, o_fault = 0.
- Fault counter pcnt, 16 bits:
  - Cleared on reset, and held at 0 while i_inject = 0 or i_fault_period = 0.
  - Otherwise it increments on each valid final-stage result.
  - When pcnt ≥ i_fault_period − 1, that result has bit i_fault_bit inverted, o_fault = 1, and pcnt returns to 0. Using ≥ covers a period that is lowered mid-run.
  - Period 1 faults every valid result.
- o_fault_ctr increments on each o_fault and sticks at all-ones.
- i_fault_bit ≥ WIDTH (non-power-of-two WIDTH only): no bit is inverted, but the fault is still counted.
- Reset mid-operation: all valid tags are cleared, so in-flight transactions are discarded and produce no o_valid. Outputs return to their reset values.

## Timing
- Operands sampled at edge N appear on o_dut_out and o_valid after edge N+LATENCY−1, i.e. usable on cycle N+LATENCY. With LATENCY = 2 this matches the existing adder's timing.
- o_fault is aligned with its o_valid.
- o_fault_ctr updates one cycle after the o_fault it counts.
- i_inject, i_fault_period and i_fault_bit are sampled at the final stage, not at entry. Changes take effect on the next valid result.
- After reset deasserts, the first o_valid occurs LATENCY cycles after the first cycle with i_enable = 1.

## Configuration
- DUT_MODEL_FAULT_EN defined: fault injection is present as described above.
- DUT_MODEL_FAULT_EN undefined:
  - The injector is not instantiated, and i_inject, i_fault_period and i_fault_bit are ignored.
  - o_fault is constant 0 and o_fault_ctr is constant 0.
  - Results are always exact.

## Structure
- Shared package dut_model_pkg holds:
  - OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - LATENCY_MAX = 8.
  - FAULT_PERIOD_W = 16.
- One sub-module, dut_fault_injector, sits at the pipeline output. It contains pcnt, the bit-invert logic and the saturating o_fault_ctr. It is instantiated only under DUT_MODEL_FAULT_EN.
- The pipeline (operand and tag registers, add/sub) stays in dut_model.

## Test plan
- Add wrap, LATENCY = 2: a = 32'hFFFF_FFFF, b = 1, op = 0, enable for 1 cycle → two cycles later o_dut_out = 0 and o_valid = 1 for exactly 1 cycle.
- Subtract wrap: a = 0, b = 1, op = 1 → o_dut_out = 32'hFFFF_FFFF; then a = 10, b = 3, op = 1 → 7 on the following cycle.
- Fault rate: a = 5, b = 3 continuously, i_inject = 1, period = 4, bit = 0 → results 8, 8, 8, 9 repeating. o_fault is high on each 9, and o_fault_ctr = 3 after 12 results.
- Bubble: enable pattern 1, 0, 1 with sums 4 then 6 → o_valid pattern 1, 0, 1. o_dut_out stays 4 through the bubble cycle, then becomes 6.
- Reset mid-flight: assert reset one cycle after an enabled transaction enters → no o_valid ever appears for it. All outputs read 0, and the next fault lands a full period after release.
- Macro off: repeat the fault-rate scenario without DUT_MODEL_FAULT_EN → every result is 8, o_fault never asserts, o_fault_ctr = 0.
